// File: rtl/tmr_pkg.sv
// Shared types for the TMR voter: channel health states, voting modes and channel count.
package tmr_pkg;

  localparam int N_CH = 3;

  typedef enum logic [1:0] {
    CH_OK      = 2'd0,
    CH_SUSPECT = 2'd1,
    CH_FAILED  = 2'd2
  } ch_state_e;

  typedef enum logic [1:0] {
    MODE_TMR     = 2'd0,
    MODE_DUPLEX  = 2'd1,
    MODE_SIMPLEX = 2'd2
  } mode_e;

endpackage

// File: rtl/tmr_ch_monitor.sv
// Health tracker for one redundant channel: OK/SUSPECT/FAILED state machine,
// consecutive-fault counter and saturating total mismatch counter.
module tmr_ch_monitor
  import tmr_pkg::*;
#(
  parameter int P_CNT_W     = 8,
  parameter int P_FAULT_THR = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mismatch,
  input  logic               update_en,
  input  logic               clear,
  output logic               failed,
  output logic [P_CNT_W-1:0] err_cnt
);

  localparam logic [P_CNT_W-1:0] THR_C = P_CNT_W'(P_FAULT_THR);
  localparam logic [P_CNT_W-1:0] MAX_C = '1;

  ch_state_e          state, state_nx;
  logic [P_CNT_W-1:0] consec, consec_nx;
  logic [P_CNT_W-1:0] err_cnt_nx;

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CH_OK;
      consec  <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_nx;
      consec  <= consec_nx;
      err_cnt <= err_cnt_nx;
    end
  end

  // NOTE: every variable gets a default before any branch, otherwise an
  // unassigned path infers a latch.
  always_comb begin
    state_nx   = state;
    consec_nx  = consec;
    err_cnt_nx = err_cnt;
    if (clear) begin
      state_nx   = CH_OK;
      consec_nx  = '0;
      err_cnt_nx = '0;
    end else if (update_en && state != CH_FAILED) begin
      if (mismatch) begin
        err_cnt_nx = (err_cnt == MAX_C) ? err_cnt : err_cnt + 1'b1;
        consec_nx  = (consec >= THR_C) ? consec : consec + 1'b1;
        state_nx   = (consec_nx >= THR_C) ? CH_FAILED : CH_SUSPECT;
      end else begin
        state_nx  = CH_OK;
        consec_nx = '0;
      end
    end
  end

  assign failed = (state == CH_FAILED);

endmodule

// File: rtl/tmr_voter_seq.sv
// Registered fault-tracking TMR voter with duplex/simplex degradation.
// Optional test-injection ports are enabled by defining TMR_ERR_INJECT_EN.
module tmr_voter_seq
  import tmr_pkg::*;
#(
  parameter int P_WIDTH     = 32,
  parameter int P_CNT_W     = 8,
  parameter int P_FAULT_THR = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] data_in1,
  input  logic [P_WIDTH-1:0] data_in2,
  input  logic [P_WIDTH-1:0] data_in3,
  input  logic               clear_faults,
`ifdef TMR_ERR_INJECT_EN
  input  logic               inj_en,
  input  logic [1:0]         inj_ch,
  input  logic [P_WIDTH-1:0] inj_mask,
`endif
  output logic               out_valid,
  output logic [P_WIDTH-1:0] data_out,
  output logic [P_WIDTH-1:0] error_vector,
  output logic [2:0]         err_ch,
  output logic [2:0]         ch_failed,
  output logic [P_CNT_W-1:0] err_cnt1,
  output logic [P_CNT_W-1:0] err_cnt2,
  output logic [P_CNT_W-1:0] err_cnt3,
  output logic               uncorrectable
);

  logic [P_WIDTH-1:0] ch [N_CH];
  logic [P_WIDTH-1:0] maj;
  logic [P_CNT_W-1:0] cnt [N_CH];
  mode_e              mode;

  logic [P_WIDTH-1:0] v_data, v_ev, lo, hi;
  logic [2:0]         v_err;
  logic               v_unc;

  always_comb begin
    ch[0] = data_in1;
    ch[1] = data_in2;
    ch[2] = data_in3;
`ifdef TMR_ERR_INJECT_EN
    for (int k = 0; k < N_CH; k++) begin
      if (inj_en && inj_ch == 2'(k + 1)) ch[k] = ch[k] ^ inj_mask;
    end
`endif
  end

  assign maj = (ch[0] & ch[1]) | (ch[0] & ch[2]) | (ch[1] & ch[2]);

  always_comb begin
    case (ch_failed)
      3'b000:                 mode = MODE_TMR;
      3'b001, 3'b010, 3'b100: mode = MODE_DUPLEX;
      default:                mode = MODE_SIMPLEX;
    endcase
  end

  // The surviving pair in duplex mode, lower index first.
  always_comb begin
    lo = ch[0];
    hi = ch[1];
    if (ch_failed[0]) begin
      lo = ch[1];
      hi = ch[2];
    end else if (ch_failed[1]) begin
      hi = ch[2];
    end
  end

  always_comb begin
    v_data = maj;
    v_ev   = '0;
    v_err  = '0;
    v_unc  = 1'b0;
    case (mode)
      MODE_TMR: begin
        v_ev = (ch[0] ^ ch[1]) | (ch[0] ^ ch[2]);
        for (int k = 0; k < N_CH; k++) v_err[k] = |(ch[k] ^ maj);
      end
      MODE_DUPLEX: begin
        v_data = lo;
        v_ev   = lo ^ hi;
        v_unc  = (lo != hi);
      end
      default: begin
        v_unc = 1'b1;
        if (!ch_failed[0])      v_data = ch[0];
        else if (!ch_failed[1]) v_data = ch[1];
        else if (!ch_failed[2]) v_data = ch[2];
        else                    v_data = ch[0];
      end
    endcase
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_mon
    tmr_ch_monitor #(
      .P_CNT_W    (P_CNT_W),
      .P_FAULT_THR(P_FAULT_THR)
    ) u_mon (
      .clk      (clk),
      .rst_n    (rst_n),
      .mismatch (v_err[k]),
      .update_en(in_valid && mode == MODE_TMR),
      .clear    (clear_faults),
      .failed   (ch_failed[k]),
      .err_cnt  (cnt[k])
    );
  end

  assign err_cnt1 = cnt[0];
  assign err_cnt2 = cnt[1];
  assign err_cnt3 = cnt[2];

  // data_out and error_vector hold across idle cycles; per-beat flags do not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      error_vector  <= '0;
      err_ch        <= '0;
      uncorrectable <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out      <= v_data;
        error_vector  <= v_ev;
        err_ch        <= v_err;
        uncorrectable <= v_unc;
      end else begin
        err_ch        <= '0;
        uncorrectable <= 1'b0;
      end
    end
  end

endmodule
